// File: rtl/seg_pkg.sv
// seg_pkg: shared digit count, digit-entry type and hex-to-segment lookup for the scan controller
package seg_pkg;
  localparam int NUM_DIGITS = 8;
  typedef struct packed {
    logic       en;
    logic       dp;
    logic [3:0] nib;
  } digit_t;
  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'hFC;
      4'h1: return 8'h60;
      4'h2: return 8'hDA;
      4'h3: return 8'hF2;
      4'h4: return 8'h66;
      4'h5: return 8'hB6;
      4'h6: return 8'hBE;
      4'h7: return 8'hE0;
      4'h8: return 8'hFE;
      4'h9: return 8'hF6;
      4'hA: return 8'hEE;
      4'hB: return 8'h3E;
      4'hC: return 8'h9C;
      4'hD: return 8'h7A;
      4'hE: return 8'h9E;
      default: return 8'h8E;
    endcase
  endfunction
  function automatic logic [7:0] digit_seg(input digit_t d);
    logic [7:0] h;
    h = hex_seg(d.nib);
    return d.en ? {~h[7:1], ~d.dp} : 8'hFF;
  endfunction
endpackage

// File: rtl/seg_rr_arb.sv
// seg_rr_arb: 2-way round-robin grant (req/gnt bit 0 = r0, bit 1 = r1), grants forced low during rst
module seg_rr_arb
  import seg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic prio_q, prio_d;
  always_comb begin
    gnt[0] = !rst && req[0] && (!req[1] || !prio_q);
    gnt[1] = !rst && req[1] && (!req[0] || prio_q);
    prio_d = gnt[0] ? 1'b1 : gnt[1] ? 1'b0 : prio_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed 7-seg driver; two writers (rX_valid/ready/idx/data/dp/en) fill the digit buffer, seg_o/an_o/scan_idx scan it
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_valid,
  output logic       r0_ready,
  input  logic [2:0] r0_idx,
  input  logic [3:0] r0_data,
  input  logic       r0_dp,
  input  logic       r0_en,
  input  logic       r1_valid,
  output logic       r1_ready,
  input  logic [2:0] r1_idx,
  input  logic [3:0] r1_data,
  input  logic       r1_dp,
  input  logic       r1_en,
  output logic [7:0] seg_o,
  output logic [7:0] an_o,
  output logic [2:0] scan_idx
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [1:0]    gnt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    seg_q, seg_d, an_q, an_d;
  logic          blank, wrap;
  digit_t        buf_q [NUM_DIGITS];
  digit_t        buf_d [NUM_DIGITS];
  seg_rr_arb u_arb (
    .clk (clk),
    .rst (rst),
    .req ({r1_valid, r0_valid}),
    .gnt (gnt)
  );
  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];
  // Outputs are decoded from next-state values so the registered pins line up
  // with the prescaler phase and a buffer write shows on the very next cycle.
  always_comb begin
    wrap  = cnt_q == CW'(SCAN_DIV - 1);
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
    idx_d = wrap ? idx_q + 3'd1 : idx_q;
    buf_d = buf_q;
    if (gnt[0])      buf_d[r0_idx] = {r0_en, r0_dp, r0_data};
    else if (gnt[1]) buf_d[r1_idx] = {r1_en, r1_dp, r1_data};
    blank = cnt_d < CW'(BLANK_CYC);
    an_d  = blank ? 8'hFF : ~(8'd1 << idx_d);
    seg_d = blank ? 8'hFF : digit_seg(buf_d[idx_d]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      seg_q <= 8'hFF;
      an_q  <= 8'hFF;
      buf_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      an_q  <= an_d;
      buf_q <= buf_d;
    end
  assign seg_o    = seg_q;
  assign an_o     = an_q;
  assign scan_idx = idx_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl with SCAN_DIV=4, BLANK_CYC=1
module tb_seg_scan_ctrl;
  localparam int DIV = 4;
  localparam int BLK = 1;
  logic clk = 0, rst = 0;
  logic r0_valid = 0, r0_ready, r0_dp = 0, r0_en = 0;
  logic r1_valid = 0, r1_ready, r1_dp = 0, r1_en = 0;
  logic [2:0] r0_idx = 0, r1_idx = 0, scan_idx;
  logic [3:0] r0_data = 0, r1_data = 0;
  logic [7:0] seg_o, an_o;
  int total = 0, passed = 0;
  int t;
  logic [5:0] mbuf [8];
  bit last1;
  logic [7:0] hex_tab [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                               8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
  typedef struct {
    logic v0; logic [2:0] i0; logic [3:0] d0; logic p0; logic e0;
    logic v1; logic [2:0] i1; logic [3:0] d1; logic p1; logic e1;
    logic er0; logic er1;
  } vec_t;
  vec_t tbl [12];
  seg_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_CYC(BLK)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_idx(r0_idx), .r0_data(r0_data), .r0_dp(r0_dp), .r0_en(r0_en),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_idx(r1_idx), .r1_data(r1_data), .r1_dp(r1_dp), .r1_en(r1_en),
    .seg_o(seg_o), .an_o(an_o), .scan_idx(scan_idx)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at t=%0d: got %h expected %h", nm, t, act, exp);
  endtask
  function automatic int m_slot(); return (t / DIV) % 8; endfunction
  function automatic int m_ph(); return t % DIV; endfunction
  function automatic logic [7:0] m_an();
    return m_ph() < BLK ? 8'hFF : ~(8'd1 << m_slot());
  endfunction
  function automatic logic [7:0] m_seg();
    logic [5:0] e;
    logic [7:0] p;
    e = mbuf[m_slot()];
    if (m_ph() < BLK || !e[5]) return 8'hFF;
    p = ~hex_tab[e[3:0]];
    p[0] = ~e[4];
    return p;
  endfunction
  function automatic logic m_g0(); return r0_valid && (!r1_valid || last1); endfunction
  function automatic logic m_g1(); return r1_valid && (!r0_valid || !last1); endfunction
  task automatic model_reset();
    t = 0;
    last1 = 1;
    for (int i = 0; i < 8; i++) mbuf[i] = '0;
  endtask
  task automatic cycle();
    logic g0, g1;
    @(negedge clk);
    g0 = m_g0();
    g1 = m_g1();
    check("an_o", an_o, m_an());
    check("seg_o", seg_o, m_seg());
    check("scan_idx", {5'd0, scan_idx}, 8'(m_slot()));
    check("r0_ready", {7'd0, r0_ready}, {7'd0, g0});
    check("r1_ready", {7'd0, r1_ready}, {7'd0, g1});
    @(posedge clk);
    if (g0) begin mbuf[r0_idx] = {r0_en, r0_dp, r0_data}; last1 = 0; end
    else if (g1) begin mbuf[r1_idx] = {r1_en, r1_dp, r1_data}; last1 = 1; end
    t++;
    #1;
  endtask
  task automatic idle();
    r0_valid = 0;
    r1_valid = 0;
  endtask
  task automatic seek(input int sl, input int ph);
    idle();
    for (int k = 0; k < 8 * DIV + 1 && !(m_slot() == sl && m_ph() == ph); k++) cycle();
    check("seek", 8'(m_slot() * DIV + m_ph()), 8'(sl * DIV + ph));
  endtask
  initial begin
    tbl[0]  = '{1, 3'd2, 4'h3, 0, 1,  1, 3'd2, 4'h5, 0, 1,  1, 0};
    tbl[1]  = '{0, 3'd0, 4'h0, 0, 0,  1, 3'd2, 4'h5, 0, 1,  0, 1};
    tbl[2]  = '{1, 3'd0, 4'h1, 0, 1,  0, 3'd0, 4'h0, 0, 0,  1, 0};
    tbl[3]  = '{0, 3'd0, 4'h0, 0, 0,  1, 3'd3, 4'h9, 1, 1,  0, 1};
    tbl[4]  = '{0, 3'd0, 4'h0, 0, 0,  1, 3'd4, 4'hA, 0, 1,  0, 1};
    tbl[5]  = '{0, 3'd0, 4'h0, 0, 0,  1, 3'd5, 4'hB, 1, 1,  0, 1};
    tbl[6]  = '{0, 3'd0, 4'h0, 0, 0,  1, 3'd6, 4'hC, 0, 1,  0, 1};
    tbl[7]  = '{0, 3'd0, 4'h0, 0, 0,  1, 3'd7, 4'hD, 0, 0,  0, 1};
    tbl[8]  = '{1, 3'd1, 4'hE, 0, 1,  1, 3'd1, 4'hF, 0, 1,  1, 0};
    tbl[9]  = '{1, 3'd1, 4'hE, 0, 1,  1, 3'd1, 4'hF, 1, 1,  0, 1};
    tbl[10] = '{1, 3'd1, 4'h2, 1, 1,  1, 3'd1, 4'h6, 0, 1,  1, 0};
    tbl[11] = '{0, 3'd0, 4'h0, 0, 0,  0, 3'd0, 4'h0, 0, 0,  0, 0};
    model_reset();
    #2 rst = 1;
    r0_valid = 1;
    r1_valid = 1;
    #10;
    check("rst an_o", an_o, 8'hFF);
    check("rst seg_o", seg_o, 8'hFF);
    check("rst scan_idx", {5'd0, scan_idx}, 8'd0);
    check("rst r0_ready", {7'd0, r0_ready}, 8'd0);
    check("rst r1_ready", {7'd0, r1_ready}, 8'd0);
    @(posedge clk);
    #1 rst = 0;
    idle();
    model_reset();
    for (int k = 0; k < 8 * DIV + 2; k++) cycle();
    for (int k = 0; k < 12; k++) begin
      {r0_valid, r0_idx, r0_data, r0_dp, r0_en} = {tbl[k].v0, tbl[k].i0, tbl[k].d0, tbl[k].p0, tbl[k].e0};
      {r1_valid, r1_idx, r1_data, r1_dp, r1_en} = {tbl[k].v1, tbl[k].i1, tbl[k].d1, tbl[k].p1, tbl[k].e1};
      #1;
      check($sformatf("tbl%0d r0_ready", k), {7'd0, r0_ready}, {7'd0, tbl[k].er0});
      check($sformatf("tbl%0d r1_ready", k), {7'd0, r1_ready}, {7'd0, tbl[k].er1});
      cycle();
    end
    seek(0, 1);
    check("slot0 an_o", an_o, 8'hFE);
    check("slot0 seg_o", seg_o, 8'h9F);
    seek(2, 1);
    check("slot2 an_o", an_o, 8'hFB);
    check("slot2 seg_o", seg_o, 8'h49);
    seek(4, 1);
    {r0_valid, r0_idx, r0_data, r0_dp, r0_en} = {1'b1, 3'd4, 4'h8, 1'b1, 1'b1};
    cycle();
    check("idx4 write seg_o", seg_o, 8'h00);
    r0_en = 0;
    cycle();
    check("idx4 disable seg_o", seg_o, 8'hFF);
    for (int k = 0; k < 300; k++) begin
      r0_valid = 1'($urandom_range(0, 1));
      r1_valid = 1'($urandom_range(0, 1));
      {r0_idx, r0_data, r0_dp, r0_en} = 9'($urandom);
      {r1_idx, r1_data, r1_dp, r1_en} = 9'($urandom);
      r0_en = r0_en | 1'($urandom_range(0, 1));
      r1_en = r1_en | 1'($urandom_range(0, 1));
      cycle();
    end
    seek(5, 2);
    #2 rst = 1;
    r0_valid = 1;
    r1_valid = 1;
    #1;
    check("async an_o", an_o, 8'hFF);
    check("async seg_o", seg_o, 8'hFF);
    check("async scan_idx", {5'd0, scan_idx}, 8'd0);
    check("async r0_ready", {7'd0, r0_ready}, 8'd0);
    check("async r1_ready", {7'd0, r1_ready}, 8'd0);
    @(posedge clk);
    #1;
    check("held an_o", an_o, 8'hFF);
    rst = 0;
    idle();
    model_reset();
    for (int k = 0; k < 8 * DIV + 2; k++) cycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
